// File: rtl/alu_result_fifo.sv
// Result FIFO between an ALU and its consumer. Each entry holds the result word plus carry/zero/neg flags.
// Optional sticky-carry accumulation is enabled with the ALU_RESULT_STICKY_CARRY_EN macro.
module alu_result_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_sticky,
  output logic                     sticky_carry
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              zero;
    logic              neg;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // Handshakes depend only on the registered count, never on in_valid/out_ready.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= '{result: in_result,
                           carry:  in_carry,
                           zero:   (in_result == '0),
                           neg:    in_result[DATA_W-1]};
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_result = head.result;
  assign out_carry  = head.carry;
  assign out_zero   = head.zero;
  assign out_neg    = head.neg;
  assign count      = count_q;

`ifdef ALU_RESULT_STICKY_CARRY_EN
  logic sticky_q, sticky_d;

  // A carry-bearing push overrides a same-cycle clear.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky)         sticky_d = 1'b0;
    if (push && in_carry)   sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_carry = sticky_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_carry      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (DATA_W=16, DEPTH=4).
// Sticky-carry expectations follow whether ALU_RESULT_STICKY_CARRY_EN is defined.
module tb_alu_result_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

`ifdef ALU_RESULT_STICKY_CARRY_EN
  localparam logic STICKY_EN = 1'b1;
`else
  localparam logic STICKY_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_carry;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_carry;
  logic              out_zero;
  logic              out_neg;
  logic [2:0]        count;
  logic              clr_sticky;
  logic              sticky_carry;

  int vectors     = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] exp_q[$];

  alu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_zero     (out_zero),
    .out_neg      (out_neg),
    .count        (count),
    .clr_sticky   (clr_sticky),
    .sticky_carry (sticky_carry)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_result = '0; in_carry = 1'b0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_sticky", sticky_carry, 0);

    // Single push, one-cycle latency
    in_valid = 1'b1; in_result = 16'h0003; in_carry = 1'b0;
    step();
    in_valid = 1'b0;
    check("lat_out_valid", out_valid, 1);
    check("lat_result", out_result, 16'h0003);
    check("lat_zero", out_zero, 0);
    check("lat_neg", out_neg, 0);
    check("lat_count", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("lat_pop_count", count, 0);
    check("lat_pop_valid", out_valid, 0);

    // Flag capture: zero value then negative value with carry
    in_valid = 1'b1; in_result = 16'h0000; in_carry = 1'b0;
    step();
    in_result = 16'h8001; in_carry = 1'b1;
    step();
    in_valid = 1'b0; in_carry = 1'b0;
    check("flags_count", count, 2);
    check("sticky_after_carry", sticky_carry, STICKY_EN);
    check("pop1_result", out_result, 16'h0000);
    check("pop1_zero", out_zero, 1);
    check("pop1_neg", out_neg, 0);
    check("pop1_carry", out_carry, 0);
    out_ready = 1'b1;
    step();
    check("pop2_result", out_result, 16'h8001);
    check("pop2_zero", out_zero, 0);
    check("pop2_neg", out_neg, 1);
    check("pop2_carry", out_carry, 1);
    check("pop2_count", count, 1);
    step();
    out_ready = 1'b0;
    check("flags_drained", count, 0);

    // Fill to full, fifth value held by upstream
    in_valid = 1'b1;
    in_result = 16'h0001; step();
    in_result = 16'h0002; step();
    in_result = 16'h0003; step();
    in_result = 16'h0004; step();
    in_result = 16'h0005;
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 4);
    step();
    check("full_hold_count", count, 4);
    check("full_hold_head", out_result, 16'h0001);
    out_ready = 1'b1;
    step();
    check("full_pop_no_push", count, 3);
    check("full_head2", out_result, 16'h0002);
    in_valid = 1'b0;
    step();
    check("full_head3", out_result, 16'h0003);
    step();
    check("full_head4", out_result, 16'h0004);
    step();
    out_ready = 1'b0;
    check("full_drained", count, 0);

    // Streaming at count=2 across pointer wrap
    in_valid = 1'b1;
    in_result = 16'h1000; step();
    in_result = 16'h1001; step();
    exp_q = '{16'h1000, 16'h1001};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_result = DATA_W'(16'h2000 + i);
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(DATA_W'(16'h2000 + i));
      check($sformatf("stream_count_%0d", i), count, 2);
      check($sformatf("stream_head_%0d", i), out_result, exp_q[0]);
    end
    in_valid = 1'b0;
    step(); step();
    out_ready = 1'b0;
    check("stream_drained", count, 0);

    // Sticky: set wins over clear, then clear alone
    in_valid = 1'b1; in_result = 16'h0007; in_carry = 1'b1; clr_sticky = 1'b1;
    step();
    check("sticky_set_wins", sticky_carry, STICKY_EN);
    in_valid = 1'b0; in_carry = 1'b0;
    step();
    clr_sticky = 1'b0;
    check("sticky_cleared", sticky_carry, 0);
    check("sticky_count", count, 1);

    // Reset mid-operation with count=3 and a push pending
    in_valid = 1'b1; in_result = 16'h0008; in_carry = 1'b1;
    step();
    in_result = 16'h0009;
    step();
    check("pre_rst_count", count, 3);
    check("pre_rst_sticky", sticky_carry, STICKY_EN);
    in_result = 16'h000A;
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0; in_carry = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_sticky", sticky_carry, 0);
    step();
    check("post_rst_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
